simd_loop_sequencer: RTL and testbench
======================================

# simd_loop_sequencer

Sequencer for the SIMD single-loop address generators. Decodes loop-configuration instructions, then drives one iteration index per cycle to the per-namespace address generators with datapath back-pressure. It generates their `start_loop`, `in_single_loop` and `current_iterations` inputs, and flags loop completion after the address pipeline has drained. One instance per SIMD lane group, placed between the instruction decoder and the address generators.

## Interface
- `OPCODE_BITS`, 4, opcode field width
- `FUNCTION_BITS`, 4, function field width
- `IMMEDIATE_WIDTH`, 32, immediate field width
- `NUM_ITER_WIDTH`, 32, iteration count/index width (≤ `IMMEDIATE_WIDTH`)
- `DRAIN_CYCLES`, 3, address-pipeline depth to drain after last iteration (≥1)
- `LOOP_OPCODE`, 4'b0111, loop-class opcode
- `FN_SET_ITER`, 4'b0010, function: load iteration count from immediate
- `FN_START`, 4'b0011, function: launch loop

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  sequencer accepts instruction; high only in IDLE
- `opcode`  in  `OPCODE_BITS`  instruction opcode
- `fn`  in  `FUNCTION_BITS`  instruction function
- `immediate`  in  `IMMEDIATE_WIDTH`  instruction immediate
- `stall`  in  1  datapath cannot take an iteration this cycle
- `start_loop`  out  1  one-cycle pulse on first RUN cycle
- `in_single_loop`  out  1  high while in RUN or DRAIN
- `iter_valid`  out  1  iteration index presented and taken this cycle
- `current_iterations`  out  `NUM_ITER_WIDTH`  1-based iteration index
- `last_iter`  out  1  `iter_valid` with final index
- `loop_done`  out  1  one-cycle completion pulse
- `busy`  out  1  state ≠ IDLE

## Operation
- Accept = `instr_valid && instr_ready`.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Accepted `LOOP_OPCODE`/`FN_SET_ITER`: `iter_count <= immediate[NUM_ITER_WIDTH-1:0]` (truncate).
  - Accepted `LOOP_OPCODE`/`FN_START` with `iter_count ≠ 0`: next state RUN; `current_iterations <= 1`.
  - Accepted `FN_START` with `iter_count = 0`: stay IDLE; `loop_done` pulses next cycle; no `start_loop`.
  - Other accepted instructions are consumed and ignored.
- RUN:
  - `iter_valid = !stall` (combinational).
  - On `iter_valid`: if `current_iterations == iter_count`, go to DRAIN with drain counter = 0; else increment `current_iterations`.
  - `stall` only holds the index; no other effect.
- DRAIN:
  - Counter increments each cycle, ignoring `stall`.
  - When counter = `DRAIN_CYCLES-1`, go to IDLE and register `loop_done`.
  - `current_iterations` holds the final index.
- `iter_count` persists across loops until the next SET_ITER, so back-to-back STARTs repeat the same count.
- No wrap-around: the index stops at `iter_count`. Max count is 2^`NUM_ITER_WIDTH`-1.

## Timing
- Reset values: state IDLE; `iter_count`, `current_iterations` = 0.
  - Outputs: `instr_ready`=1; `start_loop`, `in_single_loop`, `iter_valid`, `last_iter`, `loop_done`, `busy` = 0.
- START accepted at edge k: RUN from k+1; `start_loop` high during k+1..k+2 only. The first index (1) is presented in that cycle, gated by `stall`.
- No stall, count N: `iter_valid` for N consecutive cycles. Then DRAIN for `DRAIN_CYCLES` cycles. `loop_done` high in the first IDLE cycle, with `instr_ready`=1 in the same cycle.
- START to `loop_done`: latency = 1 + N + `DRAIN_CYCLES` + stall cycles.
- `instr_ready` is combinational from state, so no instruction is accepted in RUN or DRAIN.
- Asynchronous reset mid-loop: immediate return to IDLE with reset values. No `loop_done` is issued for the aborted loop.

## Configuration
- `SIMD_LOOP_SEQ_PERF_EN` defined:
  - Adds output `stall_count` [31:0], reset 0.
  - Cleared on START accept.
  - Increments each RUN cycle with `stall`=1; saturates at 32'hFFFF_FFFF.
  - Holds its value after the loop.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- SET_ITER 5, START, `stall`=0:
  - `start_loop` pulses once.
  - `current_iterations` 1,2,3,4,5 on consecutive `iter_valid` cycles; `last_iter` at 5.
  - `loop_done` 3 cycles after the last iteration (`DRAIN_CYCLES`=3).
- SET_ITER 4, START, `stall` high on the 2nd and 3rd RUN cycles:
  - Index 2 is held and presented over 3 cycles.
  - `loop_done` 2 cycles later than the unstalled case.
  - `stall_count`=2 with `SIMD_LOOP_SEQ_PERF_EN`.
- SET_ITER 0, START: no `start_loop`, no `iter_valid`; `loop_done` the cycle after accept.
- SET_ITER 3, then START twice: the second START is held off (`instr_ready`=0) until `loop_done`, then runs 3 iterations again.
- SET_ITER 6, START, assert `reset_n`=0 at iteration 3:
  - All outputs return to reset values immediately; no `loop_done`.
  - After release, START runs 0 iterations (count reset) and pulses `loop_done`.
- SET_ITER with immediate 32'hFFFF_FFFF and `NUM_ITER_WIDTH`=8: `iter_count`=255; the loop ends at index 255 without wrap.

Source files
------------

// File: rtl/simd_loop_sequencer_if.sv
// Instruction, back-pressure and address-generator control bundle for simd_loop_sequencer.
// master = decoder/datapath side, slave = the sequencer itself.
interface simd_loop_sequencer_if #(
  parameter int OPCODE_BITS     = 4,
  parameter int FUNCTION_BITS   = 4,
  parameter int IMMEDIATE_WIDTH = 32,
  parameter int NUM_ITER_WIDTH  = 32
);
  logic                       instr_valid;
  logic                       instr_ready;
  logic [OPCODE_BITS-1:0]     opcode;
  logic [FUNCTION_BITS-1:0]   fn;
  logic [IMMEDIATE_WIDTH-1:0] immediate;
  logic                       stall;
  logic                       start_loop;
  logic                       in_single_loop;
  logic                       iter_valid;
  logic [NUM_ITER_WIDTH-1:0]  current_iterations;
  logic                       last_iter;
  logic                       loop_done;
  logic                       busy;

  modport master (
    output instr_valid, opcode, fn, immediate, stall,
    input  instr_ready, start_loop, in_single_loop, iter_valid,
           current_iterations, last_iter, loop_done, busy
  );

  modport slave (
    input  instr_valid, opcode, fn, immediate, stall,
    output instr_ready, start_loop, in_single_loop, iter_valid,
           current_iterations, last_iter, loop_done, busy
  );
endinterface

// File: rtl/simd_loop_sequencer.sv
// Single-loop sequencer: decodes SET_ITER/START, walks the iteration index under stall,
// drains the address pipeline, then pulses loop_done. SIMD_LOOP_SEQ_PERF_EN adds stall_count.
module simd_loop_sequencer #(
  parameter int                 OPCODE_BITS     = 4,
  parameter int                 FUNCTION_BITS   = 4,
  parameter int                 IMMEDIATE_WIDTH = 32,
  parameter int                 NUM_ITER_WIDTH  = 32,
  parameter int                 DRAIN_CYCLES    = 3,
  parameter logic [OPCODE_BITS-1:0]   LOOP_OPCODE = 4'b0111,
  parameter logic [FUNCTION_BITS-1:0] FN_SET_ITER = 4'b0010,
  parameter logic [FUNCTION_BITS-1:0] FN_START    = 4'b0011
) (
  input  logic clk,
  input  logic reset_n,
  simd_loop_sequencer_if.slave bus
`ifdef SIMD_LOOP_SEQ_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_ITER_WIDTH-1:0] iter_count_q;
  logic [NUM_ITER_WIDTH-1:0] cur_iter_q;
  logic [DW-1:0]             drain_cnt_q;
  logic                      start_loop_q;
  logic                      loop_done_q;

  logic accept;
  logic is_loop_op;
  logic is_set;
  logic is_start;
  logic start_go;
  logic start_empty;
  logic final_hit;
  logic drain_end;

  logic instr_ready_c;
  logic iter_valid_c;
  logic in_loop_c;
  logic busy_c;
  logic last_iter_c;

  // Upper immediate bits beyond the counter width are deliberately truncated.
  logic unused_imm;
  assign unused_imm = ^bus.immediate;

  assign accept      = bus.instr_valid && instr_ready_c;
  assign is_loop_op  = accept && (bus.opcode == LOOP_OPCODE);
  assign is_set      = is_loop_op && (bus.fn == FN_SET_ITER);
  assign is_start    = is_loop_op && (bus.fn == FN_START);
  assign start_go    = is_start && (iter_count_q != '0);
  assign start_empty = is_start && (iter_count_q == '0);
  assign final_hit   = (cur_iter_q == iter_count_q);
  assign drain_end   = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_RUN;
      S_RUN:   if (iter_valid_c && final_hit) state_d = S_DRAIN;
      S_DRAIN: if (drain_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    instr_ready_c = 1'b0;
    in_loop_c     = 1'b0;
    busy_c        = 1'b1;
    iter_valid_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready_c = 1'b1;
        busy_c        = 1'b0;
      end
      S_RUN: begin
        in_loop_c    = 1'b1;
        iter_valid_c = !bus.stall;
      end
      S_DRAIN: begin
        in_loop_c = 1'b1;
      end
      default: begin
        instr_ready_c = 1'b0;
      end
    endcase
    last_iter_c = iter_valid_c && final_hit;
  end

  // Loop bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_count_q <= '0;
      cur_iter_q   <= '0;
      drain_cnt_q  <= '0;
      start_loop_q <= 1'b0;
      loop_done_q  <= 1'b0;
    end else begin
      start_loop_q <= start_go;
      loop_done_q  <= start_empty || drain_end;

      if (is_set) begin
        iter_count_q <= bus.immediate[NUM_ITER_WIDTH-1:0];
      end

      // Index stops at iter_count; a stalled cycle simply holds it.
      if (start_go) begin
        cur_iter_q <= NUM_ITER_WIDTH'(1);
      end else if (iter_valid_c && !final_hit) begin
        cur_iter_q <= cur_iter_q + NUM_ITER_WIDTH'(1);
      end

      if (state_q == S_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + DW'(1);
      end else begin
        drain_cnt_q <= '0;
      end
    end
  end

`ifdef SIMD_LOOP_SEQ_PERF_EN
  // Stall counter: cleared by any accepted START, saturating, held after the loop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (is_start) begin
      stall_count <= '0;
    end else if ((state_q == S_RUN) && bus.stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

  assign bus.instr_ready        = instr_ready_c;
  assign bus.start_loop         = start_loop_q;
  assign bus.in_single_loop     = in_loop_c;
  assign bus.iter_valid         = iter_valid_c;
  assign bus.current_iterations = cur_iter_q;
  assign bus.last_iter          = last_iter_c;
  assign bus.loop_done          = loop_done_q;
  assign bus.busy               = busy_c;

endmodule

// File: tb/tb_simd_loop_sequencer.sv
// Randomized bench for simd_loop_sequencer (NUM_ITER_WIDTH=8, DRAIN_CYCLES=3) against a
// loop-level reference: N taken iterations, stalls only delay, then DRAIN_CYCLES, then loop_done.
module tb_simd_loop_sequencer;

  localparam int NW = 8;
  localparam int DC = 3;
  localparam logic [3:0] OP_LOOP = 4'b0111;
  localparam logic [3:0] F_SET   = 4'b0010;
  localparam logic [3:0] F_START = 4'b0011;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;
  int   model_cnt;
`ifdef SIMD_LOOP_SEQ_PERF_EN
  logic [31:0] stall_count;
`endif

  simd_loop_sequencer_if #(.OPCODE_BITS(4), .FUNCTION_BITS(4), .IMMEDIATE_WIDTH(32),
                           .NUM_ITER_WIDTH(NW)) sif ();

  simd_loop_sequencer #(
    .OPCODE_BITS(4), .FUNCTION_BITS(4), .IMMEDIATE_WIDTH(32),
    .NUM_ITER_WIDTH(NW), .DRAIN_CYCLES(DC),
    .LOOP_OPCODE(OP_LOOP), .FN_SET_ITER(F_SET), .FN_START(F_START)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(sif)
`ifdef SIMD_LOOP_SEQ_PERF_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(sif.instr_ready), 32'd1);
    check({tag, "_start"}, 32'(sif.start_loop), 32'd0);
    check({tag, "_inloop"}, 32'(sif.in_single_loop), 32'd0);
    check({tag, "_ivalid"}, 32'(sif.iter_valid), 32'd0);
    check({tag, "_last"}, 32'(sif.last_iter), 32'd0);
    check({tag, "_done"}, 32'(sif.loop_done), 32'd0);
    check({tag, "_busy"}, 32'(sif.busy), 32'd0);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic send_instr(input logic [3:0] op, input logic [3:0] f, input logic [31:0] imm);
    sif.instr_valid = 1'b1;
    sif.opcode      = op;
    sif.fn          = f;
    sif.immediate   = imm;
    #1;
    check("instr_ready_idle", 32'(sif.instr_ready), 32'd1);
    @(posedge clk);
    if (op == OP_LOOP && f == F_SET) model_cnt = int'(imm[NW-1:0]);
    @(negedge clk);
    sif.instr_valid = 1'b0;
  endtask

  // Issue START (accepted at next posedge) and follow the whole loop cycle by cycle.
  // keep=1 leaves another START pending on the bus for back-to-back operation.
  task automatic run_loop(input bit keep, input int pct, input logic [31:0] mask);
    int  n;
    int  cyc;
    int  done_iters;
    int  stalls;
    int  last_cyc;
    bit  finished;
    bit  st;
    n          = model_cnt;
    done_iters = 0;
    stalls     = 0;
    last_cyc   = 0;
    cyc        = 0;
    finished   = 1'b0;
    sif.instr_valid = 1'b1;
    sif.opcode      = OP_LOOP;
    sif.fn          = F_START;
    sif.immediate   = 32'($urandom);
    #1;
    check("start_ready", 32'(sif.instr_ready), 32'd1);
    @(posedge clk);
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!keep) sif.instr_valid = 1'b0;
      st = ($urandom_range(99) < pct) || (cyc <= 32 && mask[cyc-1]);
      sif.stall = st;
      #1;
      if (n == 0) begin
        check("zero_done", 32'(sif.loop_done), 32'd1);
        check("zero_start", 32'(sif.start_loop), 32'd0);
        check("zero_ivalid", 32'(sif.iter_valid), 32'd0);
        check("zero_inloop", 32'(sif.in_single_loop), 32'd0);
        check("zero_ready", 32'(sif.instr_ready), 32'd1);
        finished = 1'b1;
      end else if (done_iters < n) begin
        check("run_start", 32'(sif.start_loop), 32'(cyc == 1));
        check("run_inloop", 32'(sif.in_single_loop), 32'd1);
        check("run_busy", 32'(sif.busy), 32'd1);
        check("run_ready", 32'(sif.instr_ready), 32'd0);
        check("run_done", 32'(sif.loop_done), 32'd0);
        check("run_ivalid", 32'(sif.iter_valid), 32'(!st));
        check("run_index", 32'(sif.current_iterations), 32'(done_iters + 1));
        check("run_last", 32'(sif.last_iter), 32'(!st && (done_iters + 1 == n)));
        if (st) stalls++;
        else begin
          done_iters++;
          if (done_iters == n) last_cyc = cyc;
        end
      end else if (cyc <= last_cyc + DC) begin
        check("drain_inloop", 32'(sif.in_single_loop), 32'd1);
        check("drain_ivalid", 32'(sif.iter_valid), 32'd0);
        check("drain_index", 32'(sif.current_iterations), 32'(n));
        check("drain_ready", 32'(sif.instr_ready), 32'd0);
        check("drain_done", 32'(sif.loop_done), 32'd0);
      end else begin
        check("end_done", 32'(sif.loop_done), 32'd1);
        check("end_ready", 32'(sif.instr_ready), 32'd1);
        check("end_busy", 32'(sif.busy), 32'd0);
        check("end_inloop", 32'(sif.in_single_loop), 32'd0);
        check("end_latency", 32'(cyc), 32'(n + stalls + DC + 1));
`ifdef SIMD_LOOP_SEQ_PERF_EN
        check("stall_count", stall_count, 32'(stalls));
`endif
        finished = 1'b1;
      end
    end
    if (!finished) check("loop_timeout", 32'd0, 32'd1);
    sif.stall = 1'b0;
  endtask

  initial begin
    n_total         = 0;
    n_bad           = 0;
    model_cnt       = 0;
    reset_n         = 1'b0;
    sif.instr_valid = 1'b0;
    sif.opcode      = '0;
    sif.fn          = '0;
    sif.immediate   = '0;
    sif.stall       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_index", 32'(sif.current_iterations), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain 5-iteration loop, no stall
    send_instr(OP_LOOP, F_SET, 32'd5);
    run_loop(1'b0, 0, 32'h0);

    // 4 iterations, stall on 2nd and 3rd RUN cycles
    send_instr(OP_LOOP, F_SET, 32'd4);
    run_loop(1'b0, 0, 32'h6);

    // Zero count: immediate loop_done, nothing else
    send_instr(OP_LOOP, F_SET, 32'd0);
    run_loop(1'b0, 30, 32'h0);

    // Back-to-back STARTs reuse the count; the second waits for loop_done
    send_instr(OP_LOOP, F_SET, 32'd3);
    run_loop(1'b1, 0, 32'h0);
    run_loop(1'b0, 25, 32'h0);

    // Non-loop and unknown-function instructions leave the count alone
    send_instr(4'h1, F_SET, 32'd9);
    send_instr(OP_LOOP, 4'h5, 32'd11);
    run_loop(1'b0, 30, 32'h0);

    // Immediate truncated to the counter width
    send_instr(OP_LOOP, F_SET, 32'h0000_0107);
    run_loop(1'b0, 40, 32'h0);

    for (int i = 0; i < 6; i++) begin
      send_instr(OP_LOOP, F_SET, 32'($urandom_range(20, 1)) | (32'($urandom) << NW));
      run_loop(1'b0, int'($urandom_range(60)), 32'h0);
    end

    // Maximum count, no wrap
    send_instr(OP_LOOP, F_SET, 32'hFFFF_FFFF);
    run_loop(1'b0, 10, 32'h0);

    // Asynchronous reset in the middle of a loop
    send_instr(OP_LOOP, F_SET, 32'd6);
    sif.instr_valid = 1'b1;
    sif.opcode      = OP_LOOP;
    sif.fn          = F_START;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      sif.instr_valid = 1'b0;
      #1;
      check("abort_index", 32'(sif.current_iterations), 32'(c));
    end
    reset_n = 1'b0;
    model_cnt = 0;
    #1;
    check_idle_outputs("abort");
    check("abort_index0", 32'(sif.current_iterations), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("abort_no_done", 32'(sif.loop_done), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_loop(1'b0, 0, 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
